if_fetch_queue: RTL and testbench

Instruction fetch stage directly downstream of the PC register. Consumes pc/ce from the PC register and issues reads to the synchronous instruction ROM, which has 1-cycle read latency. Returned {pc, inst} pairs are buffered in a small prefetch FIFO and presented to decode over a valid/ready handshake. Supports branch flush and back-pressures the PC register through stall_o.

---
 rtl/if_fetch_queue_pkg.sv | 14 +
 rtl/if_fetch_queue_if.sv | 14 +
 rtl/if_fetch_queue_sync_fifo.sv | 59 +++++
 rtl/if_fetch_queue.sv | 86 ++++++++
 tb/tb_if_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, chip-enable
// levels and the NOP encoding shown to decode while no instruction is ready.
package if_fetch_queue_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // addi x0, x0, 0
    localparam logic [31:0] NopInst = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode handshake: the fetch stage drives the head entry, decode
// answers with ready.
interface if_fetch_queue_if #(
    parameter int AW = if_fetch_queue_pkg::InstAddrBus,
    parameter int DW = if_fetch_queue_pkg::InstBus
);
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;

    modport master (output id_valid, output id_pc, output id_inst, input id_ready);
    modport slave  (input id_valid, input id_pc, input id_inst, output id_ready);
endinterface

// File: rtl/if_fetch_queue_sync_fifo.sv
// Small prefetch FIFO with a combinational head read so decode sees the oldest
// entry in the same cycle it becomes valid; flush empties it in one cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are exactly log2(DEPTH) wide, so incrementing wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: issues PC-register addresses to a 1-cycle ROM,
// buffers returned {pc, inst} pairs and hands them to decode over valid/ready.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = InstAddrBus,
    parameter int DW    = InstBus
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           pc_i,
    input  logic                    ce_i,
    output logic                    stall_o,
    output logic                    rom_ce_o,
    output logic [AW-1:0]           rom_addr_o,
    input  logic [DW-1:0]           rom_data_i,
    input  logic                    flush_i,
    output logic [$clog2(DEPTH):0]  count_o,
    if_fetch_queue_if.master        id
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_v_q, req_v_d;
    logic [AW-1:0] req_pc_q, req_pc_d;

    logic            issue;
    logic            push;
    logic            pop;
    logic            stall;
    logic            head_valid;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [AW+DW-1:0] head;

    // A slot is reserved for every in-flight read, so a push never finds the
    // FIFO full; pops deliberately do not return credit in the same cycle.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, req_v_q};
    assign stall       = credit_used >= (CW+1)'(DEPTH);

    assign issue      = ce_i & ~stall & ~flush_i & ~rst;
    assign rom_ce_o   = issue ? ChipEnable : ChipDisable;
    assign rom_addr_o = pc_i;
    assign stall_o    = stall;

    always_comb begin
        req_v_d  = issue;
        req_pc_d = issue ? pc_i : req_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
        end else begin
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
        end
    end

    // ROM data landing in a flush cycle belongs to the discarded path.
    assign push = req_v_q & ~flush_i & ~rst;
    assign pop  = head_valid & id.id_ready & ~flush_i;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush_i),
        .wdata ({req_pc_q, rom_data_i}),
        .count (count),
        .head  (head)
    );

    assign head_valid = (count != '0);
    assign count_o    = count;

    assign id.id_valid = head_valid;
    assign id.id_pc    = head_valid ? head[AW+DW-1:DW] : '0;
    assign id.id_inst  = head_valid ? head[DW-1:0] : DW'(NopInst);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a vector table for the fill/stall/drain timeline,
// hand sequences for flush, reset and ready toggling, all backed by a scoreboard.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic          stall_o;
    logic          rom_ce_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data;
    logic          flush_i;
    logic [CW-1:0] count_o;

    if_fetch_queue_if #(.AW(AW), .DW(DW)) id_if ();

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .stall_o    (stall_o),
        .rom_ce_o   (rom_ce_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data),
        .flush_i    (flush_i),
        .count_o    (count_o),
        .id         (id_if)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM; garbage when not read so stray pushes are visible.
    always @(posedge clk) rom_data <= rom_ce_o ? rom_fn(rom_addr_o) : 32'hDEAD_BEEF;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    typedef struct {
        bit            r;
        bit            ce;
        bit            rdy;
        bit            chk;
        bit            valid;
        logic [AW-1:0] pc;
        int            cnt;
        bit            stall;
        bit            romce;
    } vec_t;

    entry_t sb[$];
    vec_t   vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] pc_model;
    bit            prev_issue;
    bit            prev_hold;
    logic [AW-1:0] hold_pc;
    logic [DW-1:0] hold_inst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit ce, input bit rdy, input bit chk, input bit v,
                       input logic [AW-1:0] p, input int cnt, input bit st, input bit rc);
        vecs.push_back('{r, ce, rdy, chk, v, p, cnt, st, rc});
    endtask

    task automatic apply(input bit r, input bit c, input bit rd, input bit f);
        rst            = r;
        ce_i           = c;
        id_if.id_ready = rd;
        flush_i        = f;
        pc_i           = pc_model;
        #1;
    endtask

    // Per-cycle invariants and scoreboard bookkeeping, then advance one clock.
    task automatic step();
        entry_t e;
        if (!id_if.id_valid) check("nop_when_idle", id_if.id_inst, NopInst);
        else                 check("inst_matches_pc", id_if.id_inst, rom_fn(id_if.id_pc));
        if (prev_hold) begin
            check("hold_valid", id_if.id_valid, 1);
            check("hold_pc", id_if.id_pc, hold_pc);
            check("hold_inst", id_if.id_inst, hold_inst);
        end
        if (prev_issue && !flush_i && !rst)
            check("no_overflow", (count_o == DEPTH) && !(id_if.id_valid && id_if.id_ready), 0);
        if (rst)     check("rom_ce_in_rst", rom_ce_o, 0);
        if (flush_i) check("rom_ce_in_flush", rom_ce_o, 0);
        if (rst || flush_i) begin
            sb.delete();
            if (rst) pc_model = '0;
        end else begin
            if (id_if.id_valid && id_if.id_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc %h expected no delivery", id_if.id_pc);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", id_if.id_pc, e.pc);
                    check("sb_inst", id_if.id_inst, e.inst);
                end
            end
            if (rom_ce_o) begin
                check("rom_addr", rom_addr_o, pc_i);
                sb.push_back('{pc_i, rom_fn(pc_i)});
                pc_model = pc_model + 4;
            end
        end
        prev_issue = rom_ce_o;
        prev_hold  = id_if.id_valid && !id_if.id_ready && !rst && !flush_i;
        hold_pc    = id_if.id_pc;
        hold_inst  = id_if.id_inst;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int delivered;
        logic [AW-1:0] exp_seq;
        int k;

        // Fill/stall/drain timeline from reset: r ce rdy chk | valid pc cnt stall rom_ce
        add(1,1,1,1, 0, 0, 0,0,0);
        add(0,1,1,1, 0, 0, 0,0,1);
        add(0,1,1,1, 0, 0, 0,0,1);
        add(0,1,1,1, 1, 0, 1,0,1);
        add(0,1,1,1, 1, 4, 1,0,1);
        add(0,1,1,1, 1, 8, 1,0,1);
        add(1,1,0,0, 0, 0, 0,0,0);
        add(1,1,0,1, 0, 0, 0,0,0);
        add(0,1,0,1, 0, 0, 0,0,1);
        add(0,1,0,1, 0, 0, 0,0,1);
        add(0,1,0,1, 1, 0, 1,0,1);
        add(0,1,0,1, 1, 0, 2,0,1);
        add(0,1,0,1, 1, 0, 3,1,0);
        add(0,1,0,1, 1, 0, 4,1,0);
        add(0,1,0,1, 1, 0, 4,1,0);
        add(0,1,1,1, 1, 0, 4,1,0);
        add(0,1,0,1, 1, 4, 3,0,1);
        add(0,1,1,1, 1, 4, 3,1,0);
        add(0,1,0,1, 1, 8, 3,0,1);
        add(0,1,0,1, 1, 8, 3,1,0);
        add(0,1,0,1, 1, 8, 4,1,0);
        add(0,1,1,1, 1, 8, 4,1,0);
        add(0,1,1,1, 1,12, 3,0,1);
        add(0,1,1,1, 1,16, 2,0,1);
        add(0,1,1,1, 1,20, 2,0,1);

        pc_model   = '0;
        prev_issue = 0;
        prev_hold  = 0;
        rst = 1; ce_i = 0; flush_i = 0; id_if.id_ready = 0; pc_i = '0;
        @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].ce, vecs[i].rdy, 0);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_valid", i), id_if.id_valid, vecs[i].valid);
                check($sformatf("vec%0d_pc", i), id_if.id_pc, vecs[i].pc);
                check($sformatf("vec%0d_inst", i), id_if.id_inst,
                      vecs[i].valid ? rom_fn(vecs[i].pc) : NopInst);
                check($sformatf("vec%0d_count", i), count_o, vecs[i].cnt);
                check($sformatf("vec%0d_stall", i), stall_o, vecs[i].stall);
                check($sformatf("vec%0d_rom_ce", i), rom_ce_o, vecs[i].romce);
            end
            step();
        end

        // Flush with three queued entries and one read in flight.
        for (k = 0; k < 10; k++) begin
            apply(0,1,0,0);
            if (count_o == 3 && stall_o) break;
            step();
        end
        check("flush_setup_count", count_o, 3);
        pc_model = 32'h100;
        apply(0,1,0,1);
        step();
        apply(0,1,0,0);
        check("post_flush_count", count_o, 0);
        check("post_flush_valid", id_if.id_valid, 0);
        check("post_flush_rom_ce", rom_ce_o, 1);
        check("post_flush_addr", rom_addr_o, 32'h100);
        step();
        got = 0;
        for (k = 0; k < 6; k++) begin
            apply(0,1,1,0);
            if (id_if.id_valid && !got) begin
                check("first_after_flush_pc", id_if.id_pc, 32'h100);
                got = 1;
            end
            step();
            if (got) break;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL first_after_flush: got no delivery expected pc 00000100");
        end

        // Reset asserted with two entries queued.
        for (k = 0; k < 10; k++) begin
            apply(0,1,0,0);
            if (count_o == 2) break;
            step();
        end
        check("rst_setup_count", count_o, 2);
        apply(1,1,0,0);
        step();
        apply(1,1,0,0);
        check("rst_valid", id_if.id_valid, 0);
        check("rst_inst", id_if.id_inst, NopInst);
        check("rst_rom_ce", rom_ce_o, 0);
        check("rst_count", count_o, 0);
        check("rst_pc", id_if.id_pc, 0);
        check("rst_stall", stall_o, 0);
        step();

        // Ready toggling every cycle over 20 fetches.
        delivered = 0;
        exp_seq   = '0;
        for (int cyc = 0; cyc < 200 && delivered < 20; cyc++) begin
            apply(0, 1, (cyc % 2) == 0, 0);
            if (id_if.id_valid && id_if.id_ready) begin
                check("toggle_seq_pc", id_if.id_pc, exp_seq);
                exp_seq = exp_seq + 4;
                delivered++;
            end
            step();
        end
        check("toggle_delivered", delivered, 20);

        // Stop fetching and drain what remains.
        for (k = 0; k < 20; k++) begin
            apply(0,0,1,0);
            if (count_o == 0 && sb.size() == 0) break;
            step();
        end
        check("drain_count", count_o, 0);
        check("drain_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
